// File: rtl/lockstep_ctrl_unit.sv
// Lockstep control/status register bank: per-channel enable, sticky mismatch flags, saturating counters, level irq.
// Optional LOCKSTEP_ERR_RESP_EN: flag unmapped / out-of-window accesses with r_opc_o=1.
module lockstep_ctrl_unit #(
    parameter int unsigned ID_WIDTH  = 5,
    parameter int unsigned NUM_CH    = 4,
    parameter int unsigned CNT_WIDTH = 16,
    parameter logic [31:0] BASE_ADDR = 32'h1020_2800
) (
    input  logic                clk_i,
    input  logic                rst_ni,
    input  logic                req_i,
    input  logic [31:0]         addr_i,
    input  logic                wen_i,
    input  logic [31:0]         wdata_i,
    input  logic [3:0]          be_i,
    input  logic [ID_WIDTH-1:0] id_i,
    output logic                gnt_o,
    output logic                r_valid_o,
    output logic                r_opc_o,
    output logic [ID_WIDTH-1:0] r_id_o,
    output logic [31:0]         r_rdata_o,
    input  logic [NUM_CH-1:0]   mismatch_i,
    output logic [NUM_CH-1:0]   lockstep_en_o,
    output logic                irq_o
);
    localparam logic [5:0]           STATUS_WORD = 6'd16;
    localparam int unsigned          CNT_WORD    = 32;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX     = '1;

    typedef enum logic {IDLE, RESP} state_e;
    state_e state, state_next;

    logic [NUM_CH-1:0]    ctrl_en, ctrl_irq_en, status, status_next;
    logic [CNT_WIDTH-1:0] cnt      [NUM_CH];
    logic [CNT_WIDTH-1:0] cnt_next [NUM_CH];
    logic [NUM_CH-1:0]    ctrl_sel, cnt_sel;
    logic [5:0]           woff;
    logic                 hit, status_sel, mapped, wr;
    logic [31:0]          rdata_c;
    logic                 unused_ok;

    assign gnt_o         = 1'b1;
    assign lockstep_en_o = ctrl_en;
    assign wr            = req_i && !wen_i;
    assign unused_ok     = ^{addr_i[1:0], wdata_i, mapped};

    // Address decode and pre-update read mux
    always_comb begin
        woff       = addr_i[7:2];
        hit        = (addr_i[31:8] == BASE_ADDR[31:8]);
        status_sel = hit && (woff == STATUS_WORD);
        ctrl_sel   = '0;
        cnt_sel    = '0;
        rdata_c    = '0;
        if (status_sel) rdata_c = 32'(status);
        for (int c = 0; c < int'(NUM_CH); c++) begin
            ctrl_sel[c] = hit && (woff == 6'(c));
            cnt_sel[c]  = hit && (woff == 6'(int'(CNT_WORD) + c));
            if (ctrl_sel[c]) rdata_c = {30'd0, ctrl_irq_en[c], ctrl_en[c]};
            if (cnt_sel[c])  rdata_c = 32'(cnt[c]);
        end
        mapped = status_sel || (|ctrl_sel) || (|cnt_sel);
    end

    // Sticky flags and counters: mismatch is applied after software clear, so set/increment wins
    always_comb begin
        status_next = status;
        for (int c = 0; c < int'(NUM_CH); c++) begin
            cnt_next[c] = cnt[c];
            if (wr && status_sel && be_i[c/8] && wdata_i[c]) status_next[c] = 1'b0;
            if (wr && cnt_sel[c] && (be_i != 4'd0))          cnt_next[c]    = '0;
            if (mismatch_i[c] && ctrl_en[c]) begin
                status_next[c] = 1'b1;
                if (cnt_next[c] != CNT_MAX) cnt_next[c] = cnt_next[c] + CNT_WIDTH'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            ctrl_en     <= '0;
            ctrl_irq_en <= '0;
            status      <= '0;
            irq_o       <= 1'b0;
            for (int c = 0; c < int'(NUM_CH); c++) cnt[c] <= '0;
        end else begin
            for (int c = 0; c < int'(NUM_CH); c++) begin
                if (wr && ctrl_sel[c] && be_i[0]) begin
                    ctrl_en[c]     <= wdata_i[0];
                    ctrl_irq_en[c] <= wdata_i[1];
                end
                cnt[c] <= cnt_next[c];
            end
            status <= status_next;
            irq_o  <= |(status & ctrl_irq_en);
        end
    end

    // Response FSM
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) state <= IDLE;
        else         state <= state_next;
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (req_i) state_next = RESP;
            RESP:    if (!req_i) state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        r_valid_o = 1'b0;
        if (state == RESP) r_valid_o = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_id_o    <= '0;
            r_rdata_o <= '0;
        end else begin
            r_id_o    <= req_i ? id_i : '0;
            r_rdata_o <= (req_i && wen_i) ? rdata_c : '0;
        end
    end

`ifdef LOCKSTEP_ERR_RESP_EN
    logic opc_q;
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) opc_q <= 1'b0;
        else         opc_q <= req_i && !mapped;
    end
    assign r_opc_o = opc_q;
`else
    assign r_opc_o = 1'b0;
`endif

endmodule

// File: tb/tb_lockstep_ctrl_unit.sv
// Scoreboard bench for lockstep_ctrl_unit: driver pushes expected per-cycle responses from a register-level model,
// monitor pops and compares one cycle later.
module tb_lockstep_ctrl_unit;
    localparam int unsigned IDW  = 5;
    localparam int unsigned NCH  = 4;
    localparam int unsigned CW   = 4;
    localparam logic [31:0] BASE = 32'h1020_2800;
    localparam int          CMAX = (1 << CW) - 1;

    logic             clk = 1'b0, rst_n = 1'b0;
    logic             req_i = 1'b0, wen_i = 1'b0;
    logic [31:0]      addr_i = '0, wdata_i = '0;
    logic [3:0]       be_i = '0;
    logic [IDW-1:0]   id_i = '0;
    logic [NCH-1:0]   mismatch_i = '0;
    logic             gnt_o, r_valid_o, r_opc_o, irq_o;
    logic [IDW-1:0]   r_id_o;
    logic [31:0]      r_rdata_o;
    logic [NCH-1:0]   lockstep_en_o;

    always #5 clk = ~clk;

    lockstep_ctrl_unit #(.ID_WIDTH(IDW), .NUM_CH(NCH), .CNT_WIDTH(CW), .BASE_ADDR(BASE)) dut (
        .clk_i(clk), .rst_ni(rst_n), .req_i(req_i), .addr_i(addr_i), .wen_i(wen_i),
        .wdata_i(wdata_i), .be_i(be_i), .id_i(id_i), .gnt_o(gnt_o), .r_valid_o(r_valid_o),
        .r_opc_o(r_opc_o), .r_id_o(r_id_o), .r_rdata_o(r_rdata_o), .mismatch_i(mismatch_i),
        .lockstep_en_o(lockstep_en_o), .irq_o(irq_o)
    );

    typedef struct {
        logic           valid;
        logic [IDW-1:0] id;
        logic [31:0]    rdata;
        logic           opc;
        logic           irq;
        logic [NCH-1:0] en;
    } exp_t;

    exp_t q[$];
    int   total = 0, bad = 0;
    int   m_en[NCH], m_ie[NCH], m_st[NCH], m_cnt[NCH];

    function automatic void check(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic void model_reset();
        for (int c = 0; c < int'(NCH); c++) begin
            m_en[c] = 0; m_ie[c] = 0; m_st[c] = 0; m_cnt[c] = 0;
        end
    endfunction

    // One bus cycle: drive, predict the response and register effects, advance to next negedge
    task automatic step(input logic req, input logic rd, input logic [31:0] addr, input logic [31:0] wd,
                        input logic [3:0] be, input logic [IDW-1:0] id, input logic [NCH-1:0] mm);
        exp_t e;
        int   word, en_pre[NCH];
        bit   inwin, err;
        logic [31:0] rv;
        req_i = req; wen_i = rd; addr_i = addr; wdata_i = wd; be_i = be; id_i = id; mismatch_i = mm;
        inwin = (addr[31:8] == BASE[31:8]);
        word  = int'(addr[7:2]);
        rv    = '0;
        err   = !inwin;
        if (inwin) begin
            if (word < int'(NCH)) rv = 32'(m_ie[word] * 2 + m_en[word]);
            else if (word == 16) begin
                for (int c = 0; c < int'(NCH); c++) rv = rv | (32'(m_st[c]) << c);
            end else if (word >= 32 && word < 32 + int'(NCH)) rv = 32'(m_cnt[word - 32]);
            else err = 1'b1;
        end
        e.irq = 1'b0;
        for (int c = 0; c < int'(NCH); c++) if (m_st[c] != 0 && m_ie[c] != 0) e.irq = 1'b1;
        e.valid = req;
        e.id    = req ? id : '0;
        e.rdata = (req && rd) ? rv : 32'd0;
`ifdef LOCKSTEP_ERR_RESP_EN
        e.opc = req && err;
`else
        e.opc = 1'b0;
`endif
        for (int c = 0; c < int'(NCH); c++) en_pre[c] = m_en[c];
        if (req && !rd && inwin) begin
            if (word < int'(NCH) && be[0]) begin
                m_en[word] = int'(wd[0]);
                m_ie[word] = int'(wd[1]);
            end else if (word == 16) begin
                for (int c = 0; c < int'(NCH); c++) if (be[c/8] && wd[c]) m_st[c] = 0;
            end else if (word >= 32 && word < 32 + int'(NCH) && be != 4'd0) m_cnt[word - 32] = 0;
        end
        for (int c = 0; c < int'(NCH); c++) begin
            if (mm[c] && en_pre[c] != 0) begin
                m_st[c] = 1;
                if (m_cnt[c] < CMAX) m_cnt[c] = m_cnt[c] + 1;
            end
        end
        for (int c = 0; c < int'(NCH); c++) e.en[c] = (m_en[c] != 0);
        q.push_back(e);
        @(negedge clk);
    endtask

    task automatic wr(input logic [7:0] off, input logic [31:0] wd, input logic [3:0] be, input logic [NCH-1:0] mm);
        step(1'b1, 1'b0, BASE + 32'(off), wd, be, 5'($urandom), mm);
    endtask

    task automatic rd(input logic [7:0] off, input logic [NCH-1:0] mm);
        step(1'b1, 1'b1, BASE + 32'(off), 32'($urandom), 4'hF, 5'($urandom), mm);
    endtask

    task automatic idle(input int n, input logic [NCH-1:0] mm);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, '0, '0, mm);
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, r_valid_o, 0);
        check({tag, "_opc"}, r_opc_o, 0);
        check({tag, "_id"}, r_id_o, 0);
        check({tag, "_rdata"}, r_rdata_o, 0);
        check({tag, "_en"}, lockstep_en_o, 0);
        check({tag, "_irq"}, irq_o, 0);
        check({tag, "_gnt"}, gnt_o, 1);
    endtask

    // Monitor: one expected entry per cycle while out of reset
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (rst_n) begin
                if (q.size() == 0) begin
                    check("spurious_valid", r_valid_o, 0);
                end else begin
                    e = q.pop_front();
                    check("r_valid", r_valid_o, e.valid);
                    check("gnt", gnt_o, 1);
                    check("irq", irq_o, e.irq);
                    check("lockstep_en", lockstep_en_o, e.en);
                    if (e.valid) begin
                        check("r_id", r_id_o, e.id);
                        check("r_rdata", r_rdata_o, e.rdata);
                        check("r_opc", r_opc_o, e.opc);
                    end else begin
                        check("idle_rdata", r_rdata_o, 0);
                    end
                end
            end
        end
    end

    initial begin
        logic [7:0] offs[16];
        logic [7:0] off;
        model_reset();
        @(negedge clk);
        check_reset_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;

        // Control writes and byte-lane masking
        wr(8'h04, 32'h3, 4'hF, '0);
        rd(8'h04, '0);
        wr(8'h00, 32'hFFFF_FFFF, 4'h2, '0);
        rd(8'h00, '0);
        wr(8'h00, 32'hFFFF_FFFF, 4'h1, '0);
        rd(8'h00, '0);
        wr(8'h00, 32'h0, 4'hF, '0);

        // Mismatch counting, irq enable, W1C
        wr(8'h08, 32'h1, 4'hF, '0);
        for (int i = 0; i < 3; i++) begin
            idle(1, 4'b0100);
            idle(1, '0);
        end
        rd(8'h88, '0);
        rd(8'h40, '0);
        wr(8'h08, 32'h3, 4'hF, '0);
        idle(2, '0);
        wr(8'h40, 32'h4, 4'h1, '0);
        idle(2, '0);

        // Saturation, clear-vs-mismatch, W1C-vs-mismatch, read-vs-mismatch
        idle(20, 4'b0100);
        rd(8'h88, '0);
        wr(8'h88, 32'h0, 4'h8, 4'b0100);
        rd(8'h88, '0);
        wr(8'h40, 32'hF, 4'h1, 4'b0100);
        rd(8'h40, '0);
        rd(8'h88, 4'b0100);
        rd(8'h88, '0);
        wr(8'h40, 32'h4, 4'h0, '0);
        rd(8'h40, '0);

        // Unmapped and out-of-window
        rd(8'h44, '0);
        rd(8'h10, '0);
        wr(8'hFC, 32'hFFFF_FFFF, 4'hF, '0);
        step(1'b1, 1'b1, BASE + 32'h100, '0, 4'hF, 5'd9, '0);
        step(1'b1, 1'b0, 32'h0000_0004, 32'h3, 4'hF, 5'd10, '0);
        rd(8'h00, '0);

        // Back-to-back reads
        step(1'b1, 1'b1, BASE + 32'h04, '0, 4'hF, 5'd1, '0);
        step(1'b1, 1'b1, BASE + 32'h08, '0, 4'hF, 5'd2, '0);
        step(1'b1, 1'b1, BASE + 32'h40, '0, 4'hF, 5'd3, '0);
        step(1'b1, 1'b1, BASE + 32'h88, '0, 4'hF, 5'd4, '0);
        idle(1, '0);

        // Reset during the second of a back-to-back burst
        step(1'b1, 1'b1, BASE + 32'h04, '0, 4'hF, 5'd1, '0);
        req_i = 1'b1; wen_i = 1'b1; addr_i = BASE + 32'h08; id_i = 5'd2;
        #2;
        rst_n = 1'b0;
        q.delete();
        model_reset();
        #1;
        check_reset_outputs("midreset");
        @(negedge clk);
        id_i = 5'd3;
        @(negedge clk);
        id_i = 5'd4;
        #1;
        check_reset_outputs("holdreset");
        @(negedge clk);
        req_i = 1'b0;
        rst_n = 1'b1;
        idle(3, '0);
        rd(8'h04, '0);
        rd(8'h88, '0);

        // Randomised traffic
        offs[0] = 8'h00; offs[1] = 8'h04; offs[2] = 8'h08; offs[3] = 8'h0C;
        offs[4] = 8'h10; offs[5] = 8'h40; offs[6] = 8'h40; offs[7] = 8'h44;
        offs[8] = 8'h80; offs[9] = 8'h84; offs[10] = 8'h88; offs[11] = 8'h8C;
        offs[12] = 8'h90; offs[13] = 8'hC0; offs[14] = 8'h3C; offs[15] = 8'h41;
        for (int i = 0; i < 600; i++) begin
            logic [NCH-1:0] mm;
            logic [31:0]    a;
            off = offs[$urandom_range(0, 15)];
            mm  = ($urandom_range(0, 2) == 0) ? NCH'($urandom) : '0;
            a   = ($urandom_range(0, 15) == 0) ? (BASE ^ 32'h0001_0000) + 32'(off) : BASE + 32'(off);
            step(1'($urandom_range(0, 3) != 0), 1'($urandom), a, 32'($urandom), 4'($urandom),
                 5'($urandom), mm);
        end
        idle(2, '0);
        @(posedge clk);
        #3;
        check("queue_drained", 32'(q.size()), 0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/lockstep_ctrl_unit.md
Name: lockstep_ctrl_unit

Overview:
Parametrised memory-mapped control/status unit for NUM_CH lockstep core pairs, sitting as a slave on the cluster peripheral interconnect. Provides per-channel enable and interrupt-enable control, sticky mismatch flags and saturating mismatch counters fed by the lockstep comparators, and a level interrupt. Supersedes the single-register lockstep control unit with a byte-enable-aware register bank and a proper one-cycle response pipeline.

Parameters:
ID_WIDTH, 5, width of transaction ID.
NUM_CH, 4, number of lockstep channels (1..16).
CNT_WIDTH, 16, mismatch counter width (1..32).
BASE_ADDR, 32'h10202800, window base; 256-byte aligned.

Ports:
clk_i  in  1  clock
rst_ni  in  1  reset; asynchronous, active-low
req_i  in  1  request
addr_i  in  32  byte address
wen_i  in  1  1=read, 0=write
wdata_i  in  32  write data
be_i  in  4  byte enables
id_i  in  ID_WIDTH  request ID
gnt_o  out  1  grant
r_valid_o  out  1  response valid
r_opc_o  out  1  response error
r_id_o  out  ID_WIDTH  response ID
r_rdata_o  out  32  read data
mismatch_i  in  NUM_CH  one-cycle mismatch pulse per channel from comparators
lockstep_en_o  out  NUM_CH  per-channel lockstep enable (CTRL[c].bit0)
irq_o  out  1  registered interrupt

Behaviour:
- Window hit: addr_i[31:8]==BASE_ADDR[31:8]; word offset = addr_i[7:2]. Requests outside window are still granted and answered (read 0, write dropped).
- Map (byte offsets): 0x00+4c CTRL[c] RW (bit0 enable, bit1 irq_en, others read 0); 0x40 STATUS, bit c sticky error, W1C; 0x80+4c CNT[c] RO, any write with be_i!=0 clears it; else unmapped.
- gnt_o tied 1; one request accepted per cycle with req_i high.
- Response: request accepted in cycle N -> r_valid_o=1 in N+1 for reads and writes, r_id_o=id_i of N, r_rdata_o=register value sampled in N (pre-update); writes return r_rdata_o=0. Back-to-back requests give back-to-back responses. No request in N -> r_valid_o=0, r_rdata_o=0 in N+1.
- Two-state response FSM: IDLE (no pending response), RESP (response driving). IDLE->RESP on req_i; RESP->RESP on req_i; RESP->IDLE on !req_i.
- Writes honour be_i per byte lane; CTRL only updates bits in enabled lanes; STATUS W1C only on bits in enabled lanes.
- Mismatch: counted only when CTRL[c].enable=1. On mismatch_i[c]: STATUS[c]<=1, CNT[c]<=CNT[c]+1 saturating at all-ones (no wrap).
- Simultaneous: mismatch + W1C on same bit -> bit stays 1 (set wins). Mismatch + counter-clear write -> CNT[c]=1. Read and mismatch same cycle -> read returns pre-increment value.
- irq_o <= OR over c of (STATUS[c] & CTRL[c].irq_en), registered, one cycle after STATUS/CTRL update.
- Reset (any time, including mid-transaction): all registers 0, FSM IDLE, pending response discarded; outputs r_valid_o=0, r_opc_o=0, r_id_o=0, r_rdata_o=0, lockstep_en_o=0, irq_o=0; gnt_o=1.

Optional Feature:
LOCKSTEP_ERR_RESP_EN: when defined, accesses to unmapped offsets inside the window, or outside the window, and writes to read-only bits in a fully-RO register (CNT writes excluded) return r_opc_o=1 in the response cycle; write still dropped, read data 0. When undefined, r_opc_o is constant 0.

Test Plan:
- Reset, write CTRL[1]=0x3 be=0xF -> next cycle r_valid=1, r_id echoed; lockstep_en_o=4'b0010; read CTRL[1] returns 0x3.
- Write CTRL[0] wdata=0xFFFFFFFF be=0x2 -> CTRL[0] unchanged (0); be=0x1 -> reads 0x3.
- CTRL[2]=1, pulse mismatch_i[2] 3 times -> CNT[2]=3, STATUS=0x4; irq_o stays 0; set irq_en -> irq_o=1 one cycle after write; W1C STATUS 0x4 -> irq_o falls.
- CNT_WIDTH=4, 20 mismatches -> CNT=0xF (saturated); clear write concurrent with mismatch -> CNT=1; W1C concurrent with mismatch -> STATUS bit remains 1.
- Back-to-back reads to 4 offsets with ids 1..4 -> four consecutive r_valid cycles, ids in order; assert rst_ni low during the 2nd -> all outputs 0, no further r_valid.
- With LOCKSTEP_ERR_RESP_EN, read offset 0x44 -> r_opc_o=1, rdata 0; without it -> r_opc_o=0.
